// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS control FSM with mem_rdy-stretched memory states and timeout halt
module mc_ctrl_fsm #(
   parameter int WAIT_W   = 4,
   parameter int WAIT_MAX = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_rdy,
   output logic       pc_wr,
   output logic       ir_we,
   output logic       mem_rd,
   output logic       mem_we,
   output logic       iord,
   output logic       rf_we,
   output logic [1:0] reg_dst,
   output logic [1:0] mem_to_reg,
   output logic       alu_srca,
   output logic [1:0] alu_srcb,
   output logic       ext_op,
   output logic [1:0] pc_src,
   output logic [2:0] alu_op,
   output logic       illegal,
   output logic       halted,
   output logic [3:0] state
);
   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXE_R,
      S_RWB, S_EXE_I, S_IWB, S_BRANCH, S_JUMP, S_JR, S_ILLEGAL, S_HALT
   } state_t;
   localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_JAL = 6'b000011;
   localparam logic [5:0] OP_ADDIU = 6'b001001, OP_ORI = 6'b001101, OP_LUI = 6'b001111;
   localparam logic [5:0] FN_ADDU = 6'b100001, FN_SUBU = 6'b100011, FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR = 6'b100101, FN_SLT = 6'b101010, FN_JR = 6'b001000;
   state_t            r_state;
   state_t            w_dec;
   logic [WAIT_W-1:0] r_wait;
   logic              w_mem_st;
   logic              w_timeout;
   logic              w_r_alu;
   logic [2:0]        w_r_op;
   assign w_mem_st  = r_state inside {S_FETCH, S_MEMRD, S_MEMWR};
   assign w_timeout = w_mem_st && !mem_rdy && r_wait == WAIT_W'(WAIT_MAX - 1);
   assign w_r_alu   = funct inside {FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT};
   assign w_r_op    = funct == FN_SUBU ? 3'b001 : funct == FN_AND ? 3'b010 :
                      funct == FN_OR   ? 3'b011 : funct == FN_SLT ? 3'b100 : 3'b000;
   assign state     = r_state;
   // DECODE dispatch on the freshly loaded IR fields
   always_comb
      w_dec = (op == OP_LW || op == OP_SW)  ? S_MEMADR :
              (op == OP_R && funct == FN_JR) ? S_JR :
              (op == OP_R && w_r_alu)        ? S_EXE_R :
              (op inside {OP_ADDIU, OP_ORI, OP_LUI}) ? S_EXE_I :
              (op == OP_BEQ)                 ? S_BRANCH :
              (op inside {OP_J, OP_JAL})     ? S_JUMP : S_ILLEGAL;
   // state register and memory-wait counter; a timeout overrides the normal transition
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_wait  <= '0;
      end else begin
         r_wait <= (w_mem_st && !mem_rdy) ? r_wait + WAIT_W'(1) : '0;
         if (w_timeout) r_state <= S_HALT;
         else
            case (r_state)
               S_IDLE:   r_state <= S_FETCH;
               S_FETCH:  r_state <= mem_rdy ? S_DECODE : S_FETCH;
               S_DECODE: r_state <= w_dec;
               S_MEMADR: r_state <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
               S_MEMRD:  r_state <= mem_rdy ? S_MEMWB : S_MEMRD;
               S_MEMWR:  r_state <= mem_rdy ? S_FETCH : S_MEMWR;
               S_EXE_R:  r_state <= S_RWB;
               S_EXE_I:  r_state <= S_IWB;
               S_HALT:   r_state <= S_HALT;
               default:  r_state <= S_FETCH;
            endcase
      end
   end
   // datapath controls decoded from state; FETCH writes wait for mem_rdy, BRANCH writes on zero
   always_comb begin
      pc_wr = 1'b0; ir_we = 1'b0; mem_rd = 1'b0; mem_we = 1'b0; iord = 1'b0; rf_we = 1'b0;
      reg_dst = 2'b00; mem_to_reg = 2'b00; alu_srca = 1'b0; alu_srcb = 2'b00; ext_op = 1'b0;
      pc_src = 2'b00; alu_op = 3'b000; illegal = 1'b0; halted = 1'b0;
      case (r_state)
         S_FETCH: begin
            mem_rd   = 1'b1;
            ir_we    = mem_rdy;
            pc_wr    = mem_rdy;
            alu_srcb = mem_rdy ? 2'b01 : 2'b00;
         end
         S_DECODE: alu_srcb = 2'b11;
         S_MEMADR: begin
            alu_srca = 1'b1;
            alu_srcb = 2'b10;
            ext_op   = 1'b1;
         end
         S_MEMRD: begin
            mem_rd = 1'b1;
            iord   = 1'b1;
         end
         S_MEMWB: begin
            rf_we      = 1'b1;
            mem_to_reg = 2'b01;
         end
         S_MEMWR: begin
            mem_we = 1'b1;
            iord   = 1'b1;
         end
         S_EXE_R: begin
            alu_srca = 1'b1;
            alu_op   = w_r_op;
         end
         S_RWB: begin
            rf_we   = 1'b1;
            reg_dst = 2'b01;
         end
         S_EXE_I: begin
            alu_srca = 1'b1;
            alu_srcb = 2'b10;
            ext_op   = op == OP_ADDIU;
            alu_op   = op == OP_ADDIU ? 3'b000 : op == OP_ORI ? 3'b011 : 3'b101;
         end
         S_IWB: rf_we = 1'b1;
         S_BRANCH: begin
            alu_srca = 1'b1;
            alu_op   = 3'b001;
            pc_src   = 2'b01;
            pc_wr    = zero;
         end
         S_JUMP: begin
            pc_src     = 2'b10;
            pc_wr      = 1'b1;
            rf_we      = op == OP_JAL;
            reg_dst    = op == OP_JAL ? 2'b10 : 2'b00;
            mem_to_reg = op == OP_JAL ? 2'b10 : 2'b00;
         end
         S_JR: begin
            pc_src = 2'b11;
            pc_wr  = 1'b1;
         end
         S_ILLEGAL: illegal = 1'b1;
         S_HALT:    halted = 1'b1;
         default: ;
      endcase
   end
endmodule
